// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Define PS2_TX_RETRY_EN to resend a NACKed or timed-out byte once before flagging error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAIT_REL
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_d;
    logic [INH_W-1:0]       r_inh_cnt;
    logic [TO_W-1:0]        r_to_cnt;
    logic [3:0]             r_bit_cnt;
    logic                   r_nack;
    logic [7:0]             r_data;
    logic                   r_parity;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fe;
    logic                   w_accept;
    logic                   w_to_active;
    logic                   w_timeout;
    logic                   w_fail;
    logic                   w_can_retry;

    // Open-drain drive for the bit currently on the wire: oe pulls low, so oe = ~bit.
    function automatic logic send_oe(input logic [3:0] n, input logic [7:0] d, input logic p);
        logic [2:0] idx;
        idx = 3'(n - 4'd1);
        if (n == 4'd0)
            return 1'b1;
        else if (n <= 4'd8)
            return ~d[idx];
        else if (n == 4'd9)
            return ~p;
        else
            return 1'b0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_d     <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data_in};
            r_clk_d     <= w_clk_s;
        end
    end

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_fe        = r_clk_d & ~w_clk_s;
    assign w_accept    = (r_state == S_IDLE) && tx_valid;
    assign w_to_active = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_REL);
    assign w_timeout   = (r_to_cnt == TO_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        tx_ready     = 1'b0;
        busy         = 1'b1;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            S_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid)
                    w_state_next = S_INHIBIT;
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (r_inh_cnt == INH_LAST) begin
                    ps2_data_oe  = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_timeout) begin
                    w_fail = 1'b1;
                end else begin
                    ps2_data_oe = send_oe(r_bit_cnt, r_data, r_parity);
                    if (w_fe && (r_bit_cnt == 4'd9))
                        w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (w_timeout)
                    w_fail = 1'b1;
                else if (w_fe)
                    w_state_next = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (w_timeout) begin
                    w_fail = 1'b1;
                end else if (w_clk_s && w_data_s) begin
                    if (r_nack) begin
                        w_fail = 1'b1;
                    end else begin
                        done         = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // A failed attempt either restarts from the inhibit phase or ends the request.
        if (w_fail) begin
            if (w_can_retry) begin
                w_state_next = S_INHIBIT;
            end else begin
                error        = 1'b1;
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inh_cnt <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_nack    <= 1'b0;
        end else begin
            if ((r_state == S_INHIBIT) && (w_state_next == S_INHIBIT))
                r_inh_cnt <= r_inh_cnt + INH_W'(1);
            else
                r_inh_cnt <= '0;

            if (r_state != S_SEND)
                r_bit_cnt <= '0;
            else if (w_fe)
                r_bit_cnt <= r_bit_cnt + 4'd1;

            if (!w_to_active || w_fe)
                r_to_cnt <= '0;
            else if (!w_timeout)
                r_to_cnt <= r_to_cnt + TO_W'(1);

            if ((r_state == S_ACK) && w_fe)
                r_nack <= w_data_s;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data   <= tx_data;
            r_parity <= ~^tx_data;
        end
    end

`ifdef PS2_TX_RETRY_EN
    logic r_retried;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_retried <= 1'b0;
        else if (w_accept)
            r_retried <= 1'b0;
        else if (w_fail)
            r_retried <= 1'b1;
    end

    assign w_can_retry = ~r_retried;
`else
    assign w_can_retry = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: keyboard-side device model on the open-drain pads plus a byte scoreboard.
// Shortened inhibit/timeout/clock periods keep the run small; honours PS2_TX_RETRY_EN.
module tb_ps2_host_tx;
    localparam int INH = 200;
    localparam int TO  = 3000;
    localparam int HP  = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int RETRY = 1;
`else
    localparam int RETRY = 0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       glitch   = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    int n_tests = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, ready_bad = 0, inh_starts = 0;
    logic prev_pulse = 1'b0, prev_clk_oe = 1'b0;
    logic snap_clk_oe, snap_data_oe, snap_busy, snap_ready;
    logic [7:0] exp_q[$];

    // Wired-AND pads: host pulls via oe, device model pulls via dev_*; glitch forces clk high.
    assign ps2_clk_in  = glitch ? 1'b1 : (~ps2_clk_oe & dev_clk);
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
        if (prev_pulse && !tx_ready && !reset) ready_bad++;
        if (ps2_clk_oe && !prev_clk_oe) inh_starts++;
        prev_pulse  = done | error;
        prev_clk_oe = ps2_clk_oe;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [7:0] b, input bit hold);
        int guard = 0;
        @(negedge clk);
        while (!tx_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Device side of one frame: measure inhibit, clock 11 edges, sample bits, optional ACK/glitch/reset.
    task automatic dev_frame(input bit ack, input int glitch_edge, input int abort_edge,
                             output logic [10:0] bits, output int inh_len);
        int  guard = 0;
        bit  aborted = 1'b0;
        bits    = '1;
        inh_len = 0;
        while (!ps2_clk_oe && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        while (ps2_clk_oe && inh_len < 4 * INH) begin
            @(negedge clk);
            inh_len++;
        end
        for (int k = 1; k <= 11 && !aborted; k++) begin
            repeat (HP) @(negedge clk);
            bits[k-1] = ps2_data_in;
            if (k == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            for (int c = 0; c < HP; c++) begin
                @(negedge clk);
                if (k == glitch_edge) glitch = (c >= 10 && c < 13);
                if (k == abort_edge && c == HP / 2) begin
                    reset = 1'b1;
                    #1;
                    snap_clk_oe  = ps2_clk_oe;
                    snap_data_oe = ps2_data_oe;
                    snap_busy    = busy;
                    snap_ready   = tx_ready;
                    aborted      = 1'b1;
                end
            end
            glitch  = 1'b0;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle(input int limit, output bit timed_out);
        int guard = 0;
        while (busy && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        timed_out = busy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_oe: got clk_oe=%b data_oe=%b, want 0 0", ps2_clk_oe, ps2_data_oe);
        end
        n_tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b, want 1 0", tx_ready, busy);
        end
        n_tests++;
        if (done !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got done=%b error=%b, want 0 0", done, error);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got ready=%b busy=%b clk_oe=%b, want 1 0 0",
                     tx_ready, busy, ps2_clk_oe);
        end
    endtask

    task automatic test_ack_ed();
        logic [10:0] bits;
        logic [7:0]  exp;
        int len, d0, e0;
        bit to;
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'hED, 1'b0);
        dev_frame(1'b1, 0, 0, bits, len);
        wait_idle(1000, to);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if (len !== INH) begin
            n_fail++;
            $display("FAIL ed_inhibit_len: got %0d cycles, want %0d", len, INH);
        end
        n_tests++;
        if (bits[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ed_start_bit: got %b, want 0", bits[0]);
        end
        n_tests++;
        if (bits[8:1] !== exp) begin
            n_fail++;
            $display("FAIL ed_data: got %h, want %h", bits[8:1], exp);
        end
        n_tests++;
        if (bits[9] !== 1'(($countones(exp) % 2) == 0)) begin
            n_fail++;
            $display("FAIL ed_parity: got %b, want 1", bits[9]);
        end
        n_tests++;
        if (bits[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL ed_stop: got %b, want 1", bits[10]);
        end
        n_tests++;
        if (to || (done_cnt - d0) != 1 || (err_cnt - e0) != 0) begin
            n_fail++;
            $display("FAIL ed_done: got hang=%0d done_cycles=%0d err_cycles=%0d, want 0 1 0",
                     to, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_nack_ff();
        logic [10:0] bits;
        logic [7:0]  exp;
        int len, d0, e0, i0, i1;
        bit to;
        d0 = done_cnt;
        e0 = err_cnt;
        i0 = inh_starts;
        send_req(8'hFF, 1'b0);
        dev_frame(1'b0, 0, 0, bits, len);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if (bits[8:1] !== exp || bits[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL ff_frame: got data=%h parity=%b, want %h 1", bits[8:1], bits[9], exp);
        end
`ifdef PS2_TX_RETRY_EN
        exp_q.push_back(8'hFF);
        dev_frame(1'b0, 0, 0, bits, len);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if (len !== INH || bits[8:1] !== exp) begin
            n_fail++;
            $display("FAIL ff_retry_frame: got len=%0d data=%h, want %0d %h", len, bits[8:1], INH, exp);
        end
`endif
        wait_idle(1000, to);
        n_tests++;
        if (to || (err_cnt - e0) != 1 || (done_cnt - d0) != 0) begin
            n_fail++;
            $display("FAIL ff_error: got hang=%0d err_cycles=%0d done_cycles=%0d, want 0 1 0",
                     to, err_cnt - e0, done_cnt - d0);
        end
        i1 = inh_starts;
        repeat (2 * INH) @(negedge clk);
        n_tests++;
        if ((inh_starts - i0) != 1 + RETRY || inh_starts != i1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_inhibits: got %0d inhibits busy=%b, want %0d busy=0",
                     inh_starts - i0, busy, 1 + RETRY);
        end
    endtask

    task automatic test_timeout();
        int guard, cnt;
        send_req(8'h00, 1'b0);
        for (int a = 0; a <= RETRY; a++) begin
            guard = 0;
            while (!ps2_clk_oe && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            guard = 0;
            while (ps2_clk_oe && guard < 4 * INH) begin
                @(negedge clk);
                guard++;
            end
            cnt = 0;
            while (!(error || ps2_clk_oe) && cnt < TO + 100) begin
                @(negedge clk);
                cnt++;
            end
            if (a == RETRY) begin
                n_tests++;
                if (error !== 1'b1 || cnt != TO) begin
                    n_fail++;
                    $display("FAIL timeout_error: got error=%b after %0d cycles, want 1 after %0d",
                             error, cnt, TO);
                end
                n_tests++;
                if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_release: got clk_oe=%b data_oe=%b, want 0 0",
                             ps2_clk_oe, ps2_data_oe);
                end
            end else begin
                n_tests++;
                if (error !== 1'b0 || ps2_clk_oe !== 1'b1 || cnt != TO + 1) begin
                    n_fail++;
                    $display("FAIL timeout_retry: got error=%b clk_oe=%b at %0d, want 0 1 at %0d",
                             error, ps2_clk_oe, cnt, TO + 1);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ready: got %b, want 1", tx_ready);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits;
        logic [7:0]  exp;
        int len, d0;
        bit to;
        send_req(8'hAA, 1'b0);
        dev_frame(1'b1, 0, 4, bits, len);
        n_tests++;
        if (snap_clk_oe !== 1'b0 || snap_data_oe !== 1'b0 || snap_busy !== 1'b0 || snap_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_reset: got clk_oe=%b data_oe=%b busy=%b ready=%b, want 0 0 0 1",
                     snap_clk_oe, snap_data_oe, snap_busy, snap_ready);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        send_req(8'hF4, 1'b0);
        dev_frame(1'b1, 0, 0, bits, len);
        wait_idle(1000, to);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if (to || bits[8:1] !== exp || (done_cnt - d0) != 1) begin
            n_fail++;
            $display("FAIL after_reset_send: got data=%h done_cycles=%0d hang=%0d, want %h 1 0",
                     bits[8:1], done_cnt - d0, to, exp);
        end
    endtask

    task automatic test_hold_valid();
        logic [10:0] bits;
        logic [7:0]  exp;
        int len, d0, i0, guard;
        bit to;
        d0 = done_cnt;
        i0 = inh_starts;
        send_req(8'hED, 1'b1);
        tx_data = 8'h55;
        exp_q.push_back(8'h55);
        dev_frame(1'b1, 0, 0, bits, len);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if (bits[8:1] !== exp || (inh_starts - i0) != 1) begin
            n_fail++;
            $display("FAIL hold_first_frame: got data=%h inhibits=%0d, want %h 1",
                     bits[8:1], inh_starts - i0, exp);
        end
        guard = 0;
        while (!tx_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        dev_frame(1'b1, 0, 0, bits, len);
        wait_idle(1000, to);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if (to || bits[8:1] !== exp || len != INH || (done_cnt - d0) != 2) begin
            n_fail++;
            $display("FAIL hold_second_frame: got data=%h len=%0d done_cycles=%0d, want %h %0d 2",
                     bits[8:1], len, done_cnt - d0, exp, INH);
        end
    endtask

    task automatic test_glitch();
        logic [10:0] bits;
        int len, d0, e0;
        bit to;
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'h3C, 1'b0);
        dev_frame(1'b1, 3, 0, bits, len);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        wait_idle(INH + TO + 2000, to);
        n_tests++;
        if (to || (err_cnt - e0) != 1 || (done_cnt - d0) != 0) begin
            n_fail++;
            $display("FAIL glitch_outcome: got hang=%0d err_cycles=%0d done_cycles=%0d, want 0 1 0",
                     to, err_cnt - e0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_ack_ed();
        test_nack_ff();
        test_timeout();
        test_reset_midframe();
        test_hold_valid();
        test_glitch();
        n_tests++;
        if (both_cnt != 0 || ready_bad != 0) begin
            n_fail++;
            $display("FAIL pulse_rules: got both_high=%0d not_ready_after_pulse=%0d, want 0 0",
                     both_cnt, ready_bad);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
